// File: rtl/alu_pkg.sv
// Shared opcode encodings and controller state type for the registered ALU.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_ADC = 3'b010;
  localparam logic [2:0] ALU_SBC = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one multiplier bit per clock, WIDTH iterations after start.
// done is combinational on the final iteration so the caller can capture product on that edge.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               run_reg;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_sum;

  assign addend  = mplier_reg[0] ? mcand_reg : '0;
  assign acc_sum = acc_reg + addend;
  assign done    = run_reg && (count_reg == CNT_W'(WIDTH - 1));
  // Product includes the partial sum of the iteration happening on this edge.
  assign product = acc_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      run_reg    <= 1'b0;
    end else if (start && !run_reg) begin
      mcand_reg  <= {{WIDTH{1'b0}}, a};
      mplier_reg <= b;
      acc_reg    <= '0;
      count_reg  <= '0;
      run_reg    <= 1'b1;
    end else if (run_reg) begin
      acc_reg    <= acc_sum;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg + 1'b1;
      if (done) begin
        run_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with flag registers and a tristate bus driver.
// Define ALU_MUL_EN to build the multi-cycle shift-add MUL opcode.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [2:0]       alu_op,
  input  logic             alu_start,
  input  logic             alu_out,
  inout  wire  [WIDTH-1:0] alu_bus,
  output logic             alu_busy,
  output logic             alu_done,
  output logic             alu_cy,
  output logic             alu_z,
  output logic             alu_n,
  output logic             alu_v
);

  alu_state_t       state_reg, state_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             cy_reg, cy_next;
  logic             z_reg, z_next;
  logic             n_reg, n_next;
  logic             v_reg, v_next;
  logic             done_reg, done_next;

  logic [WIDTH:0]   ext;
  logic             carry_in;
  logic [WIDTH-1:0] calc_res;
  logic             calc_cy;
  logic             calc_v;

`ifdef ALU_MUL_EN
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (alu_a),
    .b       (alu_b),
    .done    (mul_done),
    .product (mul_product)
  );

  assign alu_busy = (state_reg == MUL_RUN);
`else
  assign alu_busy = 1'b0;
`endif

  // Single-cycle datapath; carry-in for ADC/SBC comes from the registered flag.
  always_comb begin
    ext      = '0;
    carry_in = 1'b0;
    calc_res = '0;
    calc_cy  = 1'b0;
    calc_v   = 1'b0;
    case (alu_op)
      ALU_ADD, ALU_ADC: begin
        carry_in = (alu_op == ALU_ADC) && cy_reg;
        ext      = {1'b0, alu_a} + {1'b0, alu_b} + {{WIDTH{1'b0}}, carry_in};
        calc_res = ext[WIDTH-1:0];
        calc_cy  = ext[WIDTH];
        calc_v   = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (calc_res[WIDTH-1] != alu_a[WIDTH-1]);
      end
      ALU_SUB, ALU_SBC: begin
        carry_in = (alu_op == ALU_SBC) && cy_reg;
        ext      = {1'b0, alu_a} - {1'b0, alu_b} - {{WIDTH{1'b0}}, carry_in};
        calc_res = ext[WIDTH-1:0];
        calc_cy  = ext[WIDTH];
        calc_v   = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (calc_res[WIDTH-1] != alu_a[WIDTH-1]);
      end
      ALU_AND: calc_res = alu_a & alu_b;
      ALU_OR:  calc_res = alu_a | alu_b;
      ALU_XOR: calc_res = alu_a ^ alu_b;
      default: calc_res = '0;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    cy_next     = cy_reg;
    z_next      = z_reg;
    n_next      = n_reg;
    v_next      = v_reg;
    done_next   = 1'b0;
`ifdef ALU_MUL_EN
    mul_start   = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (alu_start) begin
          if (alu_op == ALU_MUL) begin
`ifdef ALU_MUL_EN
            mul_start  = 1'b1;
            state_next = MUL_RUN;
`else
            // Without the multiplier the opcode is a no-op that still handshakes.
            done_next  = 1'b1;
`endif
          end else begin
            result_next = calc_res;
            cy_next     = calc_cy;
            v_next      = calc_v;
            z_next      = (calc_res == '0);
            n_next      = calc_res[WIDTH-1];
            done_next   = 1'b1;
          end
        end
      end
      MUL_RUN: begin
`ifdef ALU_MUL_EN
        if (mul_done) begin
          result_next = mul_product[WIDTH-1:0];
          cy_next     = |mul_product[2*WIDTH-1:WIDTH];
          v_next      = 1'b0;
          z_next      = (mul_product[WIDTH-1:0] == '0);
          n_next      = mul_product[WIDTH-1];
          done_next   = 1'b1;
          state_next  = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      result_reg <= '0;
      cy_reg     <= 1'b0;
      z_reg      <= 1'b0;
      n_reg      <= 1'b0;
      v_reg      <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      cy_reg     <= cy_next;
      z_reg      <= z_next;
      n_reg      <= n_next;
      v_reg      <= v_next;
      done_reg   <= done_next;
    end
  end

  assign alu_done = done_reg;
  assign alu_cy   = cy_reg;
  assign alu_z    = z_reg;
  assign alu_n    = n_reg;
  assign alu_v    = v_reg;

  // Bus enable is deliberately unregistered; the previous result stays visible during MUL.
  assign alu_bus = alu_out ? result_reg : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, hand sequences, randomized ops vs model.
module tb_alu_seq;
  localparam int W = 8;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] alu_a, alu_b;
  logic [2:0]   alu_op;
  logic         alu_start, alu_out;
  wire  [W-1:0] alu_bus;
  logic         alu_busy, alu_done, alu_cy, alu_z, alu_n, alu_v;
  logic         tb_en;
  logic [W-1:0] tb_val;

  assign alu_bus = tb_en ? tb_val : {W{1'bz}};

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_start(alu_start), .alu_out(alu_out), .alu_bus(alu_bus),
    .alu_busy(alu_busy), .alu_done(alu_done), .alu_cy(alu_cy), .alu_z(alu_z),
    .alu_n(alu_n), .alu_v(alu_v)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Reference state: architectural result and flags.
  logic [W-1:0] m_res = '0;
  logic m_cy = 0, m_z = 0, m_n = 0, m_v = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, res;
    logic         cy, z, n, v;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Arithmetic in plain integers; overflow is the signed result leaving the W-bit range.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int ua, ub, sa, sb, c, r, sr, p;
    bit upd;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    c = (op == 3'd2 || op == 3'd3) ? int'(m_cy) : 0;
    upd = 1'b1;
    case (op)
      3'd0, 3'd2: begin
        r = ua + ub + c; sr = sa + sb + c;
        m_res = r[W-1:0]; m_cy = (r >= (1 << W));
        m_v = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
      end
      3'd1, 3'd3: begin
        r = ua - ub - c; sr = sa - sb - c;
        m_res = r[W-1:0]; m_cy = (r < 0);
        m_v = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
      end
      3'd4: begin m_res = a & b; m_cy = 0; m_v = 0; end
      3'd5: begin m_res = a | b; m_cy = 0; m_v = 0; end
      3'd6: begin m_res = a ^ b; m_cy = 0; m_v = 0; end
      default: begin
        if (MUL_EN) begin
          p = ua * ub;
          m_res = p[W-1:0]; m_cy = ((p >> W) != 0); m_v = 0;
        end else begin
          upd = 1'b0;
        end
      end
    endcase
    if (upd) begin
      m_z = (m_res == 0);
      m_n = m_res[W-1];
    end
  endtask

  function automatic logic [31:0] dut_state();
    return {20'd0, alu_bus, alu_cy, alu_z, alu_n, alu_v};
  endfunction

  function automatic logic [31:0] model_state();
    return {20'd0, m_res, m_cy, m_z, m_n, m_v};
  endfunction

  // Issue one op, wait out busy (bounded), check latency, done and result against the model.
  // b2b: start in the current cycle (caller is at the negedge where done is high).
  // poke_at: busy cycle at which a stray ADD start is driven (-1 for none).
  task automatic do_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit b2b, input int poke_at);
    int bc;
    logic [W-1:0] prev_res;
    if (!b2b) begin
      @(negedge clk);
      check({name, "_done_idle"}, {31'd0, alu_done}, 32'd0);
    end
    prev_res = m_res;
    alu_op = op; alu_a = a; alu_b = b; alu_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    alu_start = 1'b0;
    alu_a = W'($urandom); alu_b = W'($urandom);
    bc = 0;
    while (alu_busy && bc < 40) begin
      if (bc == 1) check({name, "_bus_during_mul"}, {24'd0, alu_bus}, {24'd0, prev_res});
      if (bc == poke_at) begin
        alu_start = 1'b1; alu_op = 3'd0; alu_a = 8'h01; alu_b = 8'h01;
      end else begin
        alu_start = 1'b0;
      end
      bc++;
      @(negedge clk);
    end
    alu_start = 1'b0;
    model(op, a, b);
    check({name, "_busy_cycles"}, bc, (MUL_EN && op == 3'd7) ? W : 0);
    check({name, "_done"}, {31'd0, alu_done}, 32'd1);
    check({name, "_res_flags"}, dut_state(), model_state());
  endtask

  initial begin
    vecs[0]  = '{3'd0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'd1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{3'd1, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{3'd2, 8'h01, 8'h01, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'd1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{3'd3, 8'h05, 8'h01, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'd6, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'd4, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'd5, 8'h80, 8'h01, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{3'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{3'd2, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{3'd0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{3'd3, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{3'd4, 8'h55, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; alu_a = '0; alu_b = '0; alu_op = '0; alu_start = 1'b0;
    alu_out = 1'b1; tb_en = 1'b0; tb_val = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, alu_busy}, 32'd0);
    check("reset_done", {31'd0, alu_done}, 32'd0);
    check("reset_res_flags", dut_state(), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, -1);
      check($sformatf("vec%0d_table", i), dut_state(),
            {20'd0, vecs[i].res, vecs[i].cy, vecs[i].z, vecs[i].n, vecs[i].v});
    end

    // Bus release and combinational enable, within one clock phase.
    do_op("xor_bus", 3'd6, 8'hAA, 8'hFF, 1'b0, -1);
    alu_out = 1'b0; tb_val = 8'hA5; tb_en = 1'b1;
    #1 check("bus_released", {24'd0, alu_bus}, 32'hA5);
    tb_en = 1'b0; alu_out = 1'b1;
    #1 check("bus_enable_comb", {24'd0, alu_bus}, 32'h55);

`ifdef ALU_MUL_EN
    do_op("mul_0c_0b", 3'd7, 8'h0C, 8'h0B, 1'b0, 3);
    check("mul_0c_0b_table", dut_state(), {20'd0, 8'h84, 1'b0, 1'b0, 1'b1, 1'b0});
    do_op("mul_10_10_b2b", 3'd7, 8'h10, 8'h10, 1'b1, -1);
    check("mul_10_10_table", dut_state(), {20'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    check("mul_stray_start_ignored", dut_state(), model_state());
`else
    do_op("add_pre_noop", 3'd0, 8'h7F, 8'h01, 1'b0, -1);
    do_op("mul_noop", 3'd7, 8'h12, 8'h34, 1'b0, -1);
    check("mul_noop_table", dut_state(), {20'd0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1});
`endif

    for (int i = 0; i < 60; i++) begin
      do_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'b0, -1);
    end

    // Reset three cycles into an operation (MUL when built, else after an ADD completes).
    @(negedge clk);
    alu_op = MUL_EN ? 3'd7 : 3'd0; alu_a = 8'h80; alu_b = 8'h80; alu_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    alu_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, alu_busy}, 32'd0);
    check("abort_done", {31'd0, alu_done}, 32'd0);
    check("abort_res_flags", dut_state(), 32'd0);
    m_res = '0; m_cy = 0; m_z = 0; m_n = 0; m_v = 0;
    @(negedge clk);
    rst = 1'b0;
    begin
      int pulses;
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (alu_done) pulses++;
      end
      check("abort_no_done", pulses, 0);
    end
    do_op("adc_after_reset", 3'd2, 8'h01, 8'h01, 1'b0, -1);
    check("adc_after_reset_table", dut_state(), {20'd0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
